// File: rtl/tiny_uart_tx_responder.sv
// tiny_uart_tx_responder
// Write-only UART transmitter that answers on the core's mem_valid/mem_ready bus.
// Registers are selected by mem_addr[3:2]: TXDATA, STATUS, BAUD and a reserved slot.
// Bytes written to TXDATA are queued in a small FIFO and sent LSB first as 8N1 frames.
// Optional feature macro: TINY_UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module tiny_uart_tx_responder #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef TINY_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } txState_e;

  // FIFO storage and bookkeeping
  logic [7:0]      fifoMem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wrPtr_q, rdPtr_q;
  logic [CntW-1:0] fifoCount_q;
  logic            fifoFull, fifoEmpty;
  logic            push, pop;

  // Bus side registers
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        reqWe_q, reqWe_d;
  logic [1:0]  reqSel_q, reqSel_d;
  logic [15:0] reqData_q, reqData_d;
  logic [1:0]  reqStrb_q, reqStrb_d;
  logic [15:0] baud_q, baud_d;
  logic        pushReq;

  // Serializer registers
  txState_e    state_q, state_d;
  logic [15:0] divCnt_q, divCnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [7:0]  txByte_q, txByte_d;
  logic        tx_q, tx_d;
  logic        loadFrame;
  logic [15:0] effDiv;

  logic        busy;
  logic [31:0] countWide;
  logic [31:0] statusWord;
  logic        unusedBits;

  assign fifoFull   = (fifoCount_q == CntW'(FIFO_DEPTH));
  assign fifoEmpty  = (fifoCount_q == '0);
  assign busy       = (state_q != IDLE);
  assign countWide  = 32'(fifoCount_q);
  assign statusWord = {24'd0, countWide[3:0], 1'b0, fifoEmpty, fifoFull, busy};
  assign effDiv     = (baud_q == 16'd0) ? 16'd1 : baud_q;

  // A push is committed at the end of the acknowledge cycle of a TXDATA write with strobe 0 set
  assign push = ready_q && reqWe_q && (reqSel_q == 2'd0) && reqStrb_q[0];

  assign unusedBits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2],
                        countWide[31:4]};

  // Bus acceptance: one-cycle acknowledge, stall TXDATA pushes while the FIFO has no free slot
  always_comb begin
    ready_d   = 1'b0;
    rdata_d   = '0;
    reqWe_d   = reqWe_q;
    reqSel_d  = reqSel_q;
    reqData_d = reqData_q;
    reqStrb_d = reqStrb_q;
    baud_d    = baud_q;
    pushReq   = mem_we && (mem_addr[3:2] == 2'd0) && mem_wstrb[0];
    if (mem_valid && !ready_q && !(pushReq && fifoFull && !pop)) begin
      ready_d   = 1'b1;
      reqWe_d   = mem_we;
      reqSel_d  = mem_addr[3:2];
      reqData_d = mem_wdata[15:0];
      reqStrb_d = mem_wstrb[1:0];
      if (!mem_we) begin
        case (mem_addr[3:2])
          2'd1:    rdata_d = statusWord;
          2'd2:    rdata_d = {16'd0, baud_q};
          default: rdata_d = '0;
        endcase
      end
    end
    if (ready_q && reqWe_q && (reqSel_q == 2'd2) && (reqStrb_q == 2'b11)) begin
      baud_d = reqData_q;
    end
  end

  // Bus registers, dropping any pending request on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      reqWe_q   <= 1'b0;
      reqSel_q  <= '0;
      reqData_q <= '0;
      reqStrb_q <= '0;
      baud_q    <= DEFAULT_DIV;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      reqWe_q   <= reqWe_d;
      reqSel_q  <= reqSel_d;
      reqData_q <= reqData_d;
      reqStrb_q <= reqStrb_d;
      baud_q    <= baud_d;
    end
  end

  // FIFO storage write; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= reqData_q[7:0];
    end
  end

  // FIFO pointers and count; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PtrW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PtrW'(1);
      fifoCount_q <= fifoCount_q + CntW'(push) - CntW'(pop);
    end
  end

  // Serializer next state: every bit lasts div cycles, frames chain without a gap
  always_comb begin
    state_d   = state_q;
    divCnt_d  = divCnt_q;
    div_d     = div_q;
    bitIdx_d  = bitIdx_q;
    txByte_d  = txByte_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    loadFrame = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifoEmpty) loadFrame = 1'b1;
      end
      START: begin
        if (divCnt_q == 16'd0) begin
          state_d  = DATA;
          bitIdx_d = 3'd0;
          tx_d     = txByte_q[0];
          divCnt_d = div_q - 16'd1;
        end else begin
          divCnt_d = divCnt_q - 16'd1;
        end
      end
      DATA: begin
        if (divCnt_q == 16'd0) begin
          divCnt_d = div_q - 16'd1;
          if (bitIdx_q == 3'd7) begin
`ifdef TINY_UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^txByte_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            tx_d     = txByte_q[bitIdx_q + 3'd1];
          end
        end else begin
          divCnt_d = divCnt_q - 16'd1;
        end
      end
`ifdef TINY_UART_TX_PARITY_EN
      PARITY: begin
        if (divCnt_q == 16'd0) begin
          state_d  = STOP;
          tx_d     = 1'b1;
          divCnt_d = div_q - 16'd1;
        end else begin
          divCnt_d = divCnt_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (divCnt_q == 16'd0) begin
          if (!fifoEmpty) begin
            loadFrame = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          divCnt_d = divCnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (loadFrame) begin
      pop      = 1'b1;
      txByte_d = fifoMem_q[rdPtr_q];
      div_d    = effDiv;
      divCnt_d = effDiv - 16'd1;
      bitIdx_d = 3'd0;
      tx_d     = 1'b0;
      state_d  = START;
    end
  end

  // Serializer registers; the line returns high immediately on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      divCnt_q <= '0;
      div_q    <= DEFAULT_DIV;
      bitIdx_q <= '0;
      txByte_q <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      divCnt_q <= divCnt_d;
      div_q    <= div_d;
      bitIdx_q <= bitIdx_d;
      txByte_q <= txByte_d;
      tx_q     <= tx_d;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign uart_tx   = tx_q;

endmodule

// File: tb/tb_tiny_uart_tx_responder.sv
// tb_tiny_uart_tx_responder
// Scoreboard bench: stimulus queues expected frames and read data, monitors pop and compare.
// Honours TINY_UART_TX_PARITY_EN so frames carry the even-parity bit when it is defined.
module tb_tiny_uart_tx_responder;

`ifdef TINY_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    int         div;
  } txExp_t;

  typedef struct {
    bit          isRead;
    logic [31:0] data;
  } busExp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        uart_tx;

  txExp_t  txExp[$];
  busExp_t busExp[$];
  int      startCyc[$];
  int      frameCount = 0;
  int      cyc = 0;
  int      baudModel = 4;
  int      nChecks = 0;
  int      nFail = 0;

  tiny_uart_tx_responder #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .uart_tx   (uart_tx)
  );

  // Free-running clock and cycle counter shared by stimulus and monitors
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus access; the expected response goes to the scoreboard before the request is driven
  task automatic applyStimulus(input bit we, input logic [1:0] regSel, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [31:0] expRd, output int ackCyc);
    busExp_t e;
    int      n;
    e.isRead = !we;
    e.data   = expRd;
    busExp.push_back(e);
    mem_valid = 1'b1;
    mem_we    = we;
    mem_addr  = {28'h0, regSel, 2'b00};
    mem_wdata = wdata;
    mem_wstrb = strb;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (mem_ready !== 1'b1 && n < 500);
    if (mem_ready !== 1'b1) begin
      checkOutput("ackTimeout", {31'd0, mem_ready}, 32'd1);
      busExp.delete(busExp.size() - 1);
    end
    ackCyc    = cyc;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic writeByte(input logic [7:0] data, input logic [3:0] strb, output int ackCyc);
    txExp_t e;
    if (strb[0]) begin
      e.data = data;
      e.div  = (baudModel == 0) ? 1 : baudModel;
      txExp.push_back(e);
    end
    applyStimulus(1'b1, 2'd0, {24'($urandom), data}, strb, 32'd0, ackCyc);
  endtask

  task automatic writeBaud(input logic [15:0] v, input logic [3:0] strb);
    int ack;
    if (strb[1:0] == 2'b11) baudModel = int'(v);
    applyStimulus(1'b1, 2'd2, {16'($urandom), v}, strb, 32'd0, ack);
  endtask

  task automatic readReg(input logic [1:0] regSel, input logic [31:0] expRd);
    int ack;
    applyStimulus(1'b0, regSel, 32'd0, 4'h0, expRd, ack);
  endtask

  task automatic drainTx();
    int guard = 0;
    while (txExp.size() != 0 && guard < 3000) begin
      waitCycles(1);
      guard++;
    end
    checkOutput("drainTimeout", txExp.size(), 32'd0);
    waitCycles(FRAME_BITS * 8);
  endtask

  // Bus monitor: every acknowledge pops one expectation; read data compared, pulse width checked
  initial begin : busMonitor
    busExp_t e;
    bit      prevReady = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        checkOutput("readyPulseWidth", {31'd0, prevReady}, 32'd0);
        if (busExp.size() == 0) begin
          checkOutput("spuriousReady", {31'd0, mem_ready}, 32'd0);
        end else begin
          e = busExp.pop_front();
          if (e.isRead) checkOutput("readData", mem_rdata, e.data);
        end
      end
      prevReady = (mem_ready === 1'b1);
    end
  end

  // Frame monitor: a falling line starts a frame that is compared bit period by bit period
  initial begin : frameMonitor
    txExp_t      e;
    logic [10:0] expBits;
    int          badCnt;
    int          guard;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && uart_tx === 1'b0) begin
        startCyc.push_back(cyc);
        frameCount++;
        if (txExp.size() == 0) begin
          checkOutput("unexpectedFrame", {31'd0, uart_tx}, 32'd1);
          guard = 0;
          while (uart_tx === 1'b0 && rst !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
          end
        end else begin
          e = txExp.pop_front();
          expBits = '1;
          expBits[0] = 1'b0;
          expBits[8:1] = e.data;
`ifdef TINY_UART_TX_PARITY_EN
          expBits[9] = ^e.data;
`endif
          aborted = 1'b0;
          for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
            badCnt = 0;
            for (int k = 0; k < e.div; k++) begin
              if (!(b == 0 && k == 0)) @(negedge clk);
              if (rst === 1'b1) begin
                aborted = 1'b1;
                break;
              end
              if (uart_tx !== expBits[b]) badCnt++;
            end
            if (!aborted) begin
              checkOutput($sformatf("frame%0d_data%02h_bit%0d_badSamples", frameCount, e.data, b),
                          badCnt, 32'd0);
            end
          end
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin : stimulus
    int ack[6];
    int dummy;
    int base;
    int target;
    int fc;
    int guard;
    logic [15:0] v;
    logic [3:0]  s;

    waitCycles(3);
    checkOutput("resetTx", {31'd0, uart_tx}, 32'd1);
    checkOutput("resetReady", {31'd0, mem_ready}, 32'd0);
    checkOutput("resetRdata", mem_rdata, 32'd0);
    rst = 1'b0;
    waitCycles(2);
    readReg(2'd1, 32'h0000_0004);
    readReg(2'd2, 32'h0000_0004);

    // Single 0x55 frame at the default divider, STATUS busy during and idle after
    base = startCyc.size();
    writeByte(8'h55, 4'h1, ack[0]);
    waitCycles(8);
    readReg(2'd1, 32'h0000_0005);
    drainTx();
    readReg(2'd1, 32'h0000_0004);
    checkOutput("frame55Start", startCyc[base], ack[0] + 2);

    // Six writes against a four-entry FIFO: the last one stalls until a slot frees
    base = startCyc.size();
    for (int i = 0; i < 6; i++) writeByte(8'(i + 1), 4'h1, ack[i]);
    waitCycles(2);
    checkOutput("framesStartedBy6", startCyc.size() - base, 32'd2);
    if (startCyc.size() >= base + 2) begin
      checkOutput("firstStartLatency", startCyc[base], ack[0] + 2);
      checkOutput("stallAckAtPop", ack[5], startCyc[base + 1]);
    end
    for (int i = 1; i < 5; i++) checkOutput($sformatf("ackSpacing%0d", i), ack[i] - ack[i - 1], 32'd2);
    drainTx();
    checkOutput("framesOf6", startCyc.size() - base, 32'd6);
    if (startCyc.size() >= base + 6) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput($sformatf("gapless%0d", i), startCyc[base + i + 1] - startCyc[base + i],
                    FRAME_BITS * 4);
      end
    end

    // Divider change mid-frame only affects the next frame
    writeByte(8'hA3, 4'h1, dummy);
    waitCycles(8);
    writeBaud(16'd2, 4'h3);
    writeByte(8'hFF, 4'h1, dummy);
    readReg(2'd2, 32'h0000_0002);
    drainTx();

    // Masked TXDATA, reserved slot and partial-strobe BAUD writes have no effect
    writeByte(8'h5A, 4'b1110, dummy);
    applyStimulus(1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, 32'd0, dummy);
    writeBaud(16'd9, 4'b0001);
    waitCycles(10);
    readReg(2'd1, 32'h0000_0004);
    readReg(2'd2, 32'h0000_0002);
    readReg(2'd3, 32'h0000_0000);
    readReg(2'd0, 32'h0000_0000);

`ifdef TINY_UART_TX_PARITY_EN
    // Parity frame at div 4 must span 44 cycles
    writeBaud(16'd4, 4'h3);
    base = startCyc.size();
    writeByte(8'h07, 4'h1, dummy);
    writeByte(8'h00, 4'h1, dummy);
    drainTx();
    if (startCyc.size() >= base + 2) checkOutput("parityFrameLen", startCyc[base + 1] - startCyc[base], 32'd44);
`endif

    // Randomized traffic with random divider per round
    for (int r = 0; r < 3; r++) begin
      v = 16'($urandom_range(0, 5));
      writeBaud(v, 4'h3);
      readReg(2'd2, {16'd0, v});
      for (int n = 0; n < 6; n++) begin
        s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        writeByte(8'($urandom), s, dummy);
        waitCycles(int'($urandom_range(0, 12)));
      end
      drainTx();
      readReg(2'd1, 32'h0000_0004);
    end

    // Reset 15 cycles into a frame with two bytes still queued
    writeBaud(16'd4, 4'h3);
    base = startCyc.size();
    writeByte(8'h11, 4'h1, dummy);
    writeByte(8'h22, 4'h1, dummy);
    writeByte(8'h33, 4'h1, dummy);
    guard = 0;
    while (startCyc.size() <= base && guard < 200) begin
      waitCycles(1);
      guard++;
    end
    checkOutput("resetFrameStarted", startCyc.size() - base, 32'd1);
    target = startCyc[base] + 15;
    guard = 0;
    while (cyc < target && guard < 200) begin
      waitCycles(1);
      guard++;
    end
    rst = 1'b1;
    txExp.delete();
    busExp.delete();
    baudModel = 4;
    waitCycles(1);
    checkOutput("txAfterMidReset", {31'd0, uart_tx}, 32'd1);
    checkOutput("readyAfterMidReset", {31'd0, mem_ready}, 32'd0);
    rst = 1'b0;
    fc = frameCount;
    waitCycles(100);
    checkOutput("noFramesAfterReset", frameCount, fc);
    readReg(2'd1, 32'h0000_0004);
    readReg(2'd2, 32'h0000_0004);

    waitCycles(5);
    checkOutput("busQueueEmpty", busExp.size(), 32'd0);
    checkOutput("txQueueEmpty", txExp.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
